// File: rtl/alu_req_driver.sv
// Sequential initiator for the combinational ALU: registers a request onto the ALU inputs,
// waits SETTLE cycles, captures result/flags and returns them. Optional checker: ALU_REQ_CHECK_EN.
module alu_req_driver #(
  parameter int DWIDTH = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DWIDTH-1:0] req_a,
  input  logic [DWIDTH-1:0] req_b,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [2:0]        alu_fun_sel,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_comp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              busy,
  output logic              chk_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.

  localparam int SCW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SCW-1:0]    cnt_q, cnt_d;
  logic [DWIDTH-1:0] alu_a_q, alu_a_d;
  logic [DWIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]        op_q, op_d;
  logic [DWIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic              capture;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    ovf_d        = ovf_q;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alu_a_d = req_a;
          alu_b_d = req_b;
          op_d    = req_op;
          cnt_d   = SCW'(SETTLE);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == SCW'(1)) begin
          capture      = 1'b1;
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_carry, alu_zero, alu_overflow, alu_comp};
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_RESP: begin
        // Returning to IDLE first means the next request waits one more edge: no bypass.
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture && alu_overflow && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      op_q         <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef ALU_REQ_CHECK_EN
  logic [DWIDTH-1:0] exp_result;
  logic              exp_zero;
  logic              chk_err_q, chk_err_d;

  // Reference model works on the latched operands, which are what the ALU is seeing.
  always_comb begin
    exp_result = '0;
    case (op_q)
      3'b000:  exp_result = alu_a_q + alu_b_q;
      3'b001:  exp_result = alu_a_q - alu_b_q;
      3'b010:  exp_result = ~alu_a_q;
      3'b011:  exp_result = alu_a_q & alu_b_q;
      3'b100:  exp_result = alu_a_q | alu_b_q;
      3'b101:  exp_result = alu_a_q ^ alu_b_q;
      default: exp_result = alu_a_q - alu_b_q;
    endcase
    exp_zero  = (exp_result == '0);
    chk_err_d = chk_err_q;
    if (capture && ((alu_result != exp_result) || (alu_zero != exp_zero))) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_fun_sel = op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign ovf_count   = ovf_q;

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed bench for alu_req_driver with a behavioural ALU attached (DWIDTH=4, SETTLE=1, CNT_W=2).
module tb_alu_req_driver;
  localparam int DW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_fun_sel;
  logic [DW-1:0] alu_result;
  logic          alu_carry, alu_zero, alu_overflow, alu_comp;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic [CW-1:0] ovf_count;
  logic          busy, chk_err;
  logic          stub_bad = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          exp_chk;

  alu_req_driver #(.DWIDTH(DW), .SETTLE(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun_sel(alu_fun_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_comp(alu_comp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .ovf_count(ovf_count), .busy(busy), .chk_err(chk_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural ALU: carry is carry-out (no-borrow for subtract), comp is signed a<b for 110, a==b for 111.
  always_comb begin
    logic [DW:0] sum;
    sum          = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_comp     = 1'b0;
    alu_result   = '0;
    case (alu_fun_sel)
      3'b000: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[DW-1:0];
        alu_carry    = sum[DW];
        alu_overflow = (alu_a[DW-1] == alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
      end
      3'b010: alu_result = ~alu_a;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a ^ alu_b;
      default: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_result   = sum[DW-1:0];
        alu_carry    = sum[DW];
        alu_overflow = (alu_a[DW-1] != alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
        if (alu_fun_sel == 3'b110) alu_comp = ($signed(alu_a) < $signed(alu_b));
        if (alu_fun_sel == 3'b111) alu_comp = (alu_a == alu_b);
      end
    endcase
    if (stub_bad) alu_result = '0;
    alu_zero = (alu_result == '0);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    check("req_ready_before_send", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("rsp_valid_in_wait", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_fun_sel"}, 32'(alu_fun_sel), 32'd0);
    check({tag, "_ovf_count"}, 32'(ovf_count), 32'd0);
    check({tag, "_chk_err"}, 32'(chk_err), 32'd0);
  endtask

  initial begin
`ifdef ALU_REQ_CHECK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // 7+1: signed overflow into 8
    send(3'b000, 4'd7, 4'd1);
    check("alu_a_driven", 32'(alu_a), 32'd7);
    check("alu_fun_sel_driven", 32'(alu_fun_sel), 32'd0);
    tick();
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_result", 32'(rsp_result), 32'd8);
    check("add_flags", 32'(rsp_flags), 32'b0010);
    check("add_ovf_count", 32'(ovf_count), 32'd1);
    tick();
    check("add_back_idle", 32'(busy), 32'd0);

    // 5-5 = 0
    send(3'b001, 4'd5, 4'd5);
    tick();
    check("sub_result", 32'(rsp_result), 32'd0);
    check("sub_flags", 32'(rsp_flags), 32'b1100);
    check("sub_ovf_count", 32'(ovf_count), 32'd1);
    tick();

    // -8 - 1 wraps to 7
    send(3'b110, 4'd8, 4'd1);
    tick();
    check("slt_result", 32'(rsp_result), 32'd7);
    check("slt_flags", 32'(rsp_flags), 32'b1011);
    check("slt_ovf_count", 32'(ovf_count), 32'd2);
    tick();

    send(3'b111, 4'd9, 4'd9);
    tick();
    check("eq_result", 32'(rsp_result), 32'd0);
    check("eq_flags", 32'(rsp_flags), 32'b1101);
    tick();

    // Response backpressure; a competing request must be ignored until IDLE.
    rsp_ready = 1'b0;
    send(3'b011, 4'd12, 4'd10);
    tick();
    check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    check("hold_result", 32'(rsp_result), 32'd8);
    req_valid = 1'b1;
    req_op    = 3'b100;
    req_a     = 4'd3;
    req_b     = 4'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_rsp_valid_stall", 32'(rsp_valid), 32'd1);
      check("hold_result_stall", 32'(rsp_result), 32'd8);
      check("hold_flags_stall", 32'(rsp_flags), 32'b0000);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_alu_a_stable", 32'(alu_a), 32'd12);
    end
    rsp_ready = 1'b1;
    tick();
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("no_bypass_alu_a", 32'(alu_a), 32'd12);
    tick();
    req_valid = 1'b0;
    check("next_accept_alu_a", 32'(alu_a), 32'd3);
    check("next_accept_fun_sel", 32'(alu_fun_sel), 32'd4);
    check("next_accept_busy", 32'(busy), 32'd1);
    tick();
    check("or_result", 32'(rsp_result), 32'd7);
    tick();

    // Reset mid-run, then saturate the 2-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_again");
    for (int i = 0; i < 5; i++) begin
      send(3'b000, 4'd7, 4'd1);
      tick();
      check("sat_result", 32'(rsp_result), 32'd8);
      check("sat_ovf_count", 32'(ovf_count), (i < 3) ? 32'(i + 1) : 32'd3);
      tick();
    end

    // Reset while in WAIT drops the operation.
    send(3'b000, 4'd2, 4'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_in_wait");
    tick();
    check("rst_in_wait_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_in_wait_idle", 32'(busy), 32'd0);

    // Faulty ALU result: checker flags it and stays flagged until reset.
    stub_bad = 1'b1;
    send(3'b000, 4'd2, 4'd3);
    tick();
    check("bad_stub_result", 32'(rsp_result), 32'd0);
    check("chk_err_set", 32'(chk_err), 32'(exp_chk));
    tick();
    stub_bad = 1'b0;
    send(3'b001, 4'd6, 4'd2);
    tick();
    check("good_after_bad_result", 32'(rsp_result), 32'd4);
    check("chk_err_sticky", 32'(chk_err), 32'(exp_chk));
    tick();
    send(3'b010, 4'd5, 4'd0);
    tick();
    check("not_result", 32'(rsp_result), 32'd10);
    check("chk_err_still", 32'(chk_err), 32'(exp_chk));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("chk_err_cleared", 32'(chk_err), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
